// File: rtl/ptcalc_mul_arbiter_if.sv
// Operand handshake and tagged-product bus shared by the ptcalc multiplier.
// slave: the arbiter (receives operands, returns products); master: requesters.
interface ptcalc_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*21-1:0] req_a;
  logic [NUM_REQ*12-1:0] req_b;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic [32:0]           res_p;

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_p
  );

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_p
  );
endinterface

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin arbiter sharing one signed 21x12->33 multiplier pipeline.
// Ports: ap_clk, ap_rst (async, active high), arb_en (grant enable),
//   vif (slave: req_valid/ready/a/b in, res_valid/id/p out), busy,
//   stat_clr / stat_grant_cnt (per-requester 16-bit saturating grant
//   counters, built only when PTCALC_MUL_ARB_STATS_EN is defined).
module ptcalc_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  arb_en,
  input  logic                  stat_clr,
  output logic                  busy,
  output logic [NUM_REQ*16-1:0] stat_grant_cnt,
  ptcalc_mul_arbiter_if.slave   vif
);

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               acc;
  logic [20:0]        a_sel;
  logic [11:0]        b_sel;

  logic [20:0]        a_q;
  logic [11:0]        b_q;
  logic [LATENCY-1:0] v_q;
  logic [ID_W-1:0]    id_q [LATENCY];
  logic [32:0]        prod;

  // Two passes: indices at/after the pointer first, then the wrap-around.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    acc    = 1'b0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!acc && vif.req_valid[i] && i >= int'(rr_ptr_q)) begin
        acc    = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!acc && vif.req_valid[i] && i < int'(rr_ptr_q)) begin
        acc    = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    if (!arb_en || ap_rst) begin
      gnt = '0;
      acc = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = vif.req_a[21*i +: 21];
        b_sel = vif.req_b[12*i +: 12];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (acc) begin
      if (gnt_id == ID_W'(NUM_REQ-1)) rr_ptr_d = '0;
      else rr_ptr_d = gnt_id + 1'b1;
    end
  end

  assign vif.req_ready = gnt;

  // Sign-extend both operands to 33 bits; the low 33 bits are exact.
  assign prod = {{12{a_q[20]}}, a_q} * {{21{b_q[11]}}, b_q};

  // Data registers load only behind a valid bit so outputs hold.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      v_q      <= '0;
      for (int k = 0; k < LATENCY; k++) id_q[k] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      v_q[0]   <= acc;
      if (acc) begin
        a_q     <= a_sel;
        b_q     <= b_sel;
        id_q[0] <= gnt_id;
      end
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) id_q[k] <= id_q[k-1];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign vif.res_p = prod;
    end else begin : g_latn
      logic [32:0] p_q [1:LATENCY-1];
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          for (int k = 1; k < LATENCY; k++) p_q[k] <= '0;
        end else begin
          if (v_q[0]) p_q[1] <= prod;
          for (int k = 2; k < LATENCY; k++) begin
            if (v_q[k-1]) p_q[k] <= p_q[k-1];
          end
        end
      end
      assign vif.res_p = p_q[LATENCY-1];
    end
  endgenerate

  assign vif.res_valid = v_q[LATENCY-1];
  assign vif.res_id    = id_q[LATENCY-1];
  assign busy          = |v_q;

`ifdef PTCALC_MUL_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grant_cnt[16*i +: 16] = cnt_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grant_cnt  = '0;
`endif

endmodule

// File: doc/ptcalc_mul_arbiter.md
Name: ptcalc_mul_arbiter

Overview:
Round-robin arbiter that time-shares one signed 21x12 -> 33-bit multiplier between NUM_REQ requesters inside the ptcalc pT-calculation datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one pair per cycle, pushes it through a LATENCY-stage registered multiply pipeline, and returns the product tagged with the requester index. It replaces per-stage private multipliers, cutting DSP count where ptcalc stages are not multiply-bound every cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LATENCY, 3, cycles from accepted handshake to res_valid (1..6)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ), minimum 1

Ports:
ap_clk  in  1  single clock, rising edge
ap_rst  in  1  asynchronous active-high reset
arb_en  in  1  when low, no new grants; in-flight operations still drain
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
req_a  in  NUM_REQ*21  packed signed 21-bit operands; requester i in bits [21i+20:21i]
req_b  in  NUM_REQ*12  packed signed 12-bit operands; requester i in bits [12i+11:12i]
res_valid  out  1  product valid
res_id  out  ID_W  requester index of the product
res_p  out  33  signed product a*b
busy  out  1  high while any pipeline stage holds a valid operation
stat_clr  in  1  clears statistics counters (optional feature)
stat_grant_cnt  out  NUM_REQ*16  packed per-requester grant counters (optional feature)

Behaviour:
- Reset (async assert, sync release): req_ready=0, res_valid=0, res_id=0, res_p=0, busy=0, rr_ptr=0, all pipeline valid bits cleared. In-flight operations are dropped and never reported.
- Arbitration is combinational from req_valid, rr_ptr and arb_en. Search starts at index rr_ptr and wraps modulo NUM_REQ. The first requester with req_valid=1 gets req_ready=1; all others get 0. If arb_en=0 or no request is valid, req_ready=0.
- Accept = req_valid[i] & req_ready[i]. On accept, rr_ptr <= (i+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Grant is not conditioned on result backpressure. The result port has no ready; consumers must accept res_valid whenever it is high.
- Pipeline: stage 1 registers a, b, id and valid of the granted requester. The product is registered through the remaining stages.
- res_valid asserts exactly LATENCY cycles after the accept edge, with res_id=i and res_p = signed(a) * signed(b).
- For LATENCY=1, the product is computed from the stage-1 registers combinationally and the output is registered on the same edge.
- Arithmetic: full-precision 33-bit signed product; no truncation, rounding or overflow. Extremes: (-2^20)*(-2^11) = +2^31 fits.
- res_p and res_id hold their last values when res_valid=0, except after reset, when they are 0.
- Throughput is one accept per cycle total. Back-to-back grants to different requesters produce back-to-back results, in grant order.
- A single requester holding req_valid continuously is granted every cycle if it is the only requester. Under contention each of K active requesters is granted once per K cycles.
- Invalid index: req_valid bits at positions >= NUM_REQ do not exist. ID_W is sized so res_id never exceeds NUM_REQ-1.
- arb_en deasserted mid-stream: new grants stop immediately (same cycle); results already in flight still emerge at their scheduled cycles.
- busy = OR of all pipeline valid bits.

Optional Feature:
Macro PTCALC_MUL_ARB_STATS_EN.
- Defined: one 16-bit saturating counter per requester, incremented on each accept of that requester. Counters stick at 0xFFFF.
- stat_clr=1 zeroes all counters synchronously and takes priority over a same-cycle increment.
- ap_rst zeroes all counters.
- Not defined: stat_grant_cnt is tied to 0, stat_clr is ignored, and no counter logic is synthesized.

Test Plan:
- Reset then single request: req 2 drives a=1000, b=-3, valid one cycle -> req_ready[2]=1 that cycle; LATENCY=3 cycles later res_valid=1, res_id=2, res_p=-3000; busy high for exactly 3 cycles.
- Full contention: all 4 req_valid held high for 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; results in the same order on 8 consecutive cycles.
- Extremes: a=-1048576, b=-2048 -> res_p=+2147483648; a=1048575, b=-2048 -> res_p=-2147481600.
- arb_en drop: requests 0 and 1 held valid, arb_en low after the first accept -> no further req_ready; the one result still appears LATENCY cycles later; nothing else follows.
- Reset mid-flight: accept two operations, assert ap_rst one cycle later -> res_valid stays 0 through and after reset; rr_ptr restarts, so requester 0 wins first after release.
- With PTCALC_MUL_ARB_STATS_EN defined: 5 accepts on req 1, then stat_clr coincident with a 6th accept -> stat_grant_cnt[1] reads 5 before the clear, 0 after.
